// File: rtl/crc_stream_pkg.sv
// rtl/crc_stream_pkg.sv - shared state encoding and byte helper for the streaming CRC engine
package crc_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } crc_state_t;

  // Bit-reverse one byte (bit 0 <-> bit 7).
  function automatic logic [7:0] reverse8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// rtl/crc_byte_step.sv - combinational MSB-first CRC update for one byte
module crc_byte_step #(
  parameter int CRC_WIDTH = 32
) (
  input  logic [CRC_WIDTH-1:0] crc_in,
  input  logic [7:0]           data_byte,
  input  logic [CRC_WIDTH-1:0] poly,
  output logic [CRC_WIDTH-1:0] crc_out
);

  // Fold the byte into the top of the register, then eight shift/reduce steps.
  always_comb begin
    crc_out = crc_in ^ (CRC_WIDTH'(data_byte) << (CRC_WIDTH - 8));
    for (int i = 0; i < 8; i++) begin
      if (crc_out[CRC_WIDTH-1]) begin
        crc_out = (crc_out << 1) ^ poly;
      end else begin
        crc_out = crc_out << 1;
      end
    end
  end

endmodule

// File: rtl/crc_stream.sv
// rtl/crc_stream.sv - streaming multi-beat CRC engine; CRC_MATCH_EN adds cfg_check/out_match
module crc_stream
  import crc_stream_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int CRC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [CRC_WIDTH-1:0]    cfg_poly,
  input  logic [CRC_WIDTH-1:0]    cfg_init,
  input  logic [CRC_WIDTH-1:0]    cfg_xor,
  input  logic                    cfg_reflect_in,
  input  logic                    cfg_reflect_out,
`ifdef CRC_MATCH_EN
  input  logic [CRC_WIDTH-1:0]    cfg_check,
`endif
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_BYTES*8-1:0] in_data,
  input  logic [DATA_BYTES-1:0]   in_keep,
  input  logic                    in_last,
  input  logic                    in_abort,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CRC_WIDTH-1:0]    out_crc,
`ifdef CRC_MATCH_EN
  output logic                    out_match,
`endif
  output logic [LEN_WIDTH-1:0]    out_len
);

  localparam int CNT_W = $clog2(DATA_BYTES + 1);
  localparam int SUM_W = LEN_WIDTH + CNT_W;

  crc_state_t                        state;
  logic [CRC_WIDTH-1:0]              poly_q;
  logic [CRC_WIDTH-1:0]              xor_q;
  logic                              refl_in_q;
  logic                              refl_out_q;
  logic [CRC_WIDTH-1:0]              acc;
  logic [LEN_WIDTH-1:0]              count;
`ifdef CRC_MATCH_EN
  logic [CRC_WIDTH-1:0]              check_q;
  logic [CRC_WIDTH-1:0]              check_e;
`endif

  logic                              accept;
  logic                              in_idle;
  logic [CRC_WIDTH-1:0]              poly_e;
  logic [CRC_WIDTH-1:0]              xor_e;
  logic                              refl_in_e;
  logic                              refl_out_e;
  logic [DATA_BYTES-1:0]             use_byte;
  logic [DATA_BYTES-1:0][7:0]        byte_in;
  logic [DATA_BYTES:0][CRC_WIDTH-1:0] chain;
  logic [DATA_BYTES-1:0][CRC_WIDTH-1:0] step_out;
  logic [CNT_W-1:0]                  beat_bytes;
  logic [SUM_W-1:0]                  len_sum;
  logic [LEN_WIDTH-1:0]              count_next;
  logic [CRC_WIDTH-1:0]              fin;
  logic [CRC_WIDTH-1:0]              fin_rev;
  logic [CRC_WIDTH-1:0]              crc_final;

  // Reset forces in_ready low; RESULT holds input off until the result is taken.
  assign in_ready = n_rst && (state != RESULT);
  assign accept   = in_valid && in_ready;
  assign in_idle  = (state == IDLE);

  // The first beat of a message uses live cfg; later beats use the copy latched then.
  assign poly_e     = in_idle ? cfg_poly        : poly_q;
  assign xor_e      = in_idle ? cfg_xor         : xor_q;
  assign refl_in_e  = in_idle ? cfg_reflect_in  : refl_in_q;
  assign refl_out_e = in_idle ? cfg_reflect_out : refl_out_q;
`ifdef CRC_MATCH_EN
  assign check_e    = in_idle ? cfg_check       : check_q;
`endif

  assign chain[0] = in_idle ? cfg_init : acc;

  // Byte chain: keep only gates bytes on the last beat; disabled bytes pass the CRC through.
  for (genvar g = 0; g < DATA_BYTES; g++) begin : g_step
    assign use_byte[g] = !in_last || in_keep[g];
    assign byte_in[g]  = refl_in_e ? reverse8(in_data[8*g +: 8]) : in_data[8*g +: 8];
    crc_byte_step #(.CRC_WIDTH(CRC_WIDTH)) u_step (
      .crc_in    (chain[g]),
      .data_byte (byte_in[g]),
      .poly      (poly_e),
      .crc_out   (step_out[g])
    );
    assign chain[g+1] = use_byte[g] ? step_out[g] : chain[g];
  end

  // Count bytes consumed this beat and add to the saturating message length.
  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (use_byte[i]) beat_bytes = beat_bytes + CNT_W'(1);
    end
    len_sum    = SUM_W'(count) + SUM_W'(beat_bytes);
    count_next = (|len_sum[SUM_W-1:LEN_WIDTH]) ? {LEN_WIDTH{1'b1}} : len_sum[LEN_WIDTH-1:0];
  end

  // Final XOR then optional reflection across the full CRC width.
  always_comb begin
    fin     = chain[DATA_BYTES] ^ xor_e;
    fin_rev = '0;
    for (int i = 0; i < CRC_WIDTH; i++) begin
      fin_rev[i] = fin[CRC_WIDTH-1-i];
    end
    crc_final = refl_out_e ? fin_rev : fin;
  end

  // Message FSM, config latch, accumulator, counter and result registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      poly_q     <= '0;
      xor_q      <= '0;
      refl_in_q  <= 1'b0;
      refl_out_q <= 1'b0;
      acc        <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_crc    <= '0;
      out_len    <= '0;
`ifdef CRC_MATCH_EN
      check_q    <= '0;
      out_match  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (in_abort) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
          end else if (accept) begin
            if (in_idle) begin
              poly_q     <= cfg_poly;
              xor_q      <= cfg_xor;
              refl_in_q  <= cfg_reflect_in;
              refl_out_q <= cfg_reflect_out;
`ifdef CRC_MATCH_EN
              check_q    <= cfg_check;
`endif
            end
            if (in_last) begin
              state     <= RESULT;
              out_valid <= 1'b1;
              out_crc   <= crc_final;
              out_len   <= count_next;
`ifdef CRC_MATCH_EN
              out_match <= (crc_final == check_e);
`endif
              acc       <= '0;
              count     <= '0;
            end else begin
              state <= ACCUM;
              acc   <= chain[DATA_BYTES];
              count <= count_next;
            end
          end
        end
        RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_stream.sv
// tb/tb_crc_stream.sv - directed self-checking bench for crc_stream (CRC-32 and CRC-16 instances)
module tb_crc_stream;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] cfg_poly, cfg_init, cfg_xor;
  logic        cfg_reflect_in, cfg_reflect_out;
  logic        in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_keep;
  logic        in_last, in_abort, out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_crc;
  logic [15:0] out_len;
  logic        in_ready16, out_valid16;
  logic [15:0] out_crc16, out_len16;
`ifdef CRC_MATCH_EN
  logic [31:0] cfg_check;
  logic        out_match, out_match16;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  crc_stream #(.DATA_BYTES(8), .CRC_WIDTH(32), .LEN_WIDTH(16)) u_dut (
    .clk(clk), .n_rst(n_rst),
    .cfg_poly(cfg_poly), .cfg_init(cfg_init), .cfg_xor(cfg_xor),
    .cfg_reflect_in(cfg_reflect_in), .cfg_reflect_out(cfg_reflect_out),
`ifdef CRC_MATCH_EN
    .cfg_check(cfg_check), .out_match(out_match),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep),
    .in_last(in_last), .in_abort(in_abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_crc(out_crc), .out_len(out_len)
  );

  crc_stream #(.DATA_BYTES(8), .CRC_WIDTH(16), .LEN_WIDTH(16)) u_dut16 (
    .clk(clk), .n_rst(n_rst),
    .cfg_poly(16'h1021), .cfg_init(16'hFFFF), .cfg_xor(16'h0000),
    .cfg_reflect_in(1'b0), .cfg_reflect_out(1'b0),
`ifdef CRC_MATCH_EN
    .cfg_check(16'h29B1), .out_match(out_match16),
`endif
    .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data), .in_keep(in_keep),
    .in_last(in_last), .in_abort(in_abort),
    .out_valid(out_valid16), .out_ready(out_ready), .out_crc(out_crc16), .out_len(out_len16)
  );

  // Protocol check: on a last beat the byte enables must be contiguous from bit 0.
  always @(posedge clk) begin
    if (n_rst && in_valid && in_ready && in_last) begin
      assert ((in_keep & (in_keep + 8'd1)) == 8'd0)
        else begin n_bad++; $error("FAIL keep_contiguous: observed %b", in_keep); end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin n_bad++; $error("FAIL %s: observed %h expected %h", tag, obs, exp); end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] p, input logic [31:0] i, input logic [31:0] x,
                         input logic ri, input logic ro);
    cfg_poly = p; cfg_init = i; cfg_xor = x; cfg_reflect_in = ri; cfg_reflect_out = ro;
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    int w;
    w = 0;
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (w == 50) check("send_ready_timeout", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_msg();
    send(64'h3837363534333231, 8'hFF, 1'b0);
    send(64'h0000000000000039, 8'h01, 1'b1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
    in_abort = 1'b0; out_ready = 1'b0;
    set_cfg(32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
`ifdef CRC_MATCH_EN
    cfg_check = 32'hCBF43926;
`endif

    // Reset state
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_crc", out_crc, 0);
    check("rst_out_len", out_len, 0);
    n_rst = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1);

    // CRC-32 over "123456789", 1-cycle result latency
    send(64'h3837363534333231, 8'hFF, 1'b0);
    check("mid_out_valid", out_valid, 0);
    send(64'h0000000000000039, 8'h01, 1'b1);
    check("crc32_valid", out_valid, 1);
    check("crc32_crc", out_crc, 32'hCBF43926);
    check("crc32_len", out_len, 9);
    check("crc16_crc", out_crc16, 16'h29B1);
    check("crc16_len", out_len16, 9);

    // Backpressure: result holds, input blocked, abort ignored in RESULT
    in_valid = 1'b1; in_data = 64'h1111111111111111; in_keep = 8'hFF; in_last = 1'b1;
    in_abort = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      in_abort = 1'b0;
      check("hold_in_ready", in_ready, 0);
      check("hold_valid", out_valid, 1);
      check("hold_crc", out_crc, 32'hCBF43926);
      check("hold_len", out_len, 9);
    end
    in_valid = 1'b0; in_last = 1'b0;
    consume();
    check("rel_out_valid", out_valid, 0);
    check("rel_in_ready", in_ready, 1);

    // CRC-32/BZIP2, cfg changed mid-message must have no effect
    set_cfg(32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    send(64'h3837363534333231, 8'hFF, 1'b0);
    set_cfg(32'h12345678, 32'h0, 32'h0, 1'b1, 1'b1);
    send(64'h0000000000000039, 8'h01, 1'b1);
    check("bzip2_crc", out_crc, 32'hFC891918);
    check("bzip2_len", out_len, 9);

    // Back-to-back messages with out_ready held high
    set_cfg(32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    out_ready = 1'b1;
    send_msg();
    check("b2b1_valid", out_valid, 1);
    check("b2b1_crc", out_crc, 32'hFC891918);
    send_msg();
    check("b2b2_valid", out_valid, 1);
    check("b2b2_crc", out_crc, 32'hFC891918);
    check("b2b2_len", out_len, 9);
    tick();
    out_ready = 1'b0;
    check("b2b_drain_valid", out_valid, 0);

    // Abort mid-message; abort beats a same-cycle last beat
    set_cfg(32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    send(64'hAAAAAAAAAAAAAAAA, 8'hFF, 1'b0);
    in_abort = 1'b1;
    send(64'h5555555555555555, 8'hFF, 1'b1);
    in_abort = 1'b0;
    check("abort_no_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    send_msg();
    check("post_abort_crc", out_crc, 32'hCBF43926);
    check("post_abort_len", out_len, 9);
    consume();

    // Reset mid-message clears outputs and progress
    send(64'hAAAAAAAAAAAAAAAA, 8'hFF, 1'b0);
    n_rst = 1'b0;
    tick();
    check("midrst_in_ready", in_ready, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_crc", out_crc, 0);
    check("midrst_len", out_len, 0);
    n_rst = 1'b1;
    tick();
    send_msg();
    check("post_rst_crc", out_crc, 32'hCBF43926);
    check("post_rst_len", out_len, 9);
    consume();

    // keep ignored on non-last beats; masked garbage on the last beat
    send(64'h3837363534333231, 8'h00, 1'b0);
    send(64'hA5A5A5A5A5A5A539, 8'h01, 1'b1);
    check("keep_ign_crc", out_crc, 32'hCBF43926);
    check("keep_ign_len", out_len, 9);
    check("keep_ign_crc16", out_crc16, 16'h29B1);
    consume();

    // Empty message: last with keep=0 gives init^xor
    send(64'hDEADBEEFDEADBEEF, 8'h00, 1'b1);
    check("empty_valid", out_valid, 1);
    check("empty_crc", out_crc, 32'h00000000);
    check("empty_len", out_len, 0);
    check("empty_crc16", out_crc16, 16'hFFFF);
    check("empty_len16", out_len16, 0);
    consume();

    // Length saturation: 8200 full beats = 65600 bytes
    for (int i = 0; i < 8199; i++) begin
      send(64'h0, 8'hFF, 1'b0);
    end
    send(64'h0, 8'hFF, 1'b1);
    check("sat_len", out_len, 16'hFFFF);
    check("sat_len16", out_len16, 16'hFFFF);
    consume();

`ifdef CRC_MATCH_EN
    cfg_check = 32'hCBF43926;
    send_msg();
    check("match_hit", out_match, 1);
    check("match16_hit", out_match16, 1);
    consume();
    cfg_check = 32'hCBF43927;
    send_msg();
    check("match_miss", out_match, 0);
    consume();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
